dcache_wb: RTL

Parametrised write-back, write-allocate, N-way set-associative L1 data cache between the memory pipeline stage and the memory/bus adapter. It generalises the team's first write-through data cache to configurable way count and line size and adds dirty tracking, victim write-back and cache maintenance operations. Storage is flop-based with a one-entry request buffer and a single blocking request in flight.

---
 rtl/dcache_wb.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_wb.sv
// Write-back, write-allocate N-way set-associative L1 data cache.
// Flop storage, one buffered request, one memory transaction at a time.
module dcache_wb #(
  parameter int INDEX_WIDTH = 4,
  parameter int OFFSET_WIDTH = 2,
  parameter int WAY = 2,
  localparam int LINE_W = 32 << OFFSET_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipeline_dcache_valid,
  output logic              dcache_pipeline_ready,
  input  logic [31:0]       addr_pipeline_dcache,
  input  logic              type_pipeline_dcache,
  input  logic [31:0]       din_pipeline_dcache,
  input  logic [3:0]        pipeline_dcache_wstrb,
  input  logic              pipeline_dcache_opflag,
  input  logic [1:0]        pipeline_dcache_op,
  output logic [31:0]       dout_dcache_pipeline,
  output logic              dcache_pipeline_done,
  output logic              dcache_mem_req,
  output logic              dcache_mem_wr,
  output logic [31:0]       addr_dcache_mem,
  output logic [LINE_W-1:0] dout_dcache_mem,
  input  logic [LINE_W-1:0] din_mem_dcache,
  input  logic              mem_dcache_addrOK,
  input  logic              mem_dcache_dataOK
);

  localparam int SETS = 1 << INDEX_WIDTH;
  localparam int WW = $clog2(WAY);
  localparam int LSB = OFFSET_WIDTH + 2;
  localparam int TAG_W = 32 - LSB - INDEX_WIDTH;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_REQ, WB_WAIT,
    RF_REQ, RF_WAIT, REFILL, RESP
  } state_t;

  state_t state;

  logic [LINE_W-1:0] data [WAY][SETS];
  logic [TAG_W-1:0]  tags [WAY][SETS];
  logic [SETS-1:0]   vld [WAY];
  logic [SETS-1:0]   dty [WAY];
  logic [WW-1:0]     rr [SETS];

  logic [TAG_W-1:0]        b_tag;
  logic [INDEX_WIDTH-1:0]  b_idx;
  logic [OFFSET_WIDTH-1:0] b_off;
  logic                    b_wr;
  logic [31:0]             b_din;
  logic [3:0]              b_strb;
  logic                    b_mop;
  logic [1:0]              b_op;

  logic [WW-1:0]     victim;
  logic [LINE_W-1:0] rf_line;

  logic              hit;
  logic [WW-1:0]     hit_way;
  logic [WW-1:0]     vic;
  logic              vic_found;
  logic [WW-1:0]     mt_way;
  logic              mt_go;
  logic [31:0]       hit_word;
  logic [31:0]       hit_mword;
  logic [LINE_W-1:0] rf_merged;
  logic [31:0]       fill_addr;
  logic [OFFSET_WIDTH+4:0] bsel;

  logic unused_addr;
  assign unused_addr = ^addr_pipeline_dcache[1:0];

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  assign dcache_pipeline_ready = (state == IDLE) && !rst;
  assign bsel = {b_off, 5'd0};
  assign fill_addr = {b_tag, b_idx, {LSB{1'b0}}};

  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAY; w++) begin
      if (vld[w][b_idx] && tags[w][b_idx] == b_tag) begin
        hit = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  // Prefer an empty way; fall back to the set's round-robin pointer.
  always_comb begin
    vic = rr[b_idx];
    vic_found = 1'b0;
    for (int w = 0; w < WAY; w++) begin
      if (!vic_found && !vld[w][b_idx]) begin
        vic = WW'(w);
        vic_found = 1'b1;
      end
    end
  end

  always_comb begin
    mt_way = (b_op == 2'd2) ? hit_way : b_tag[WW-1:0];
    mt_go = (b_op == 2'd1) || (b_op == 2'd2 && hit);
    hit_word = data[hit_way][b_idx][bsel +: 32];
    hit_mword = merge(hit_word, b_din, b_strb);
    rf_merged = rf_line;
    if (b_wr)
      rf_merged[bsel +: 32] =
        merge(rf_line[bsel +: 32], b_din, b_strb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dcache_pipeline_done <= 1'b0;
      dcache_mem_req <= 1'b0;
      dcache_mem_wr <= 1'b0;
      addr_dcache_mem <= '0;
      dout_dcache_mem <= '0;
      dout_dcache_pipeline <= '0;
      for (int w = 0; w < WAY; w++) begin
        vld[w] <= '0;
        dty[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
    end else begin
      dcache_pipeline_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pipeline_dcache_valid) begin
            b_tag <= addr_pipeline_dcache[31 -: TAG_W];
            b_idx <= addr_pipeline_dcache[LSB +: INDEX_WIDTH];
            b_off <= addr_pipeline_dcache[2 +: OFFSET_WIDTH];
            b_wr <= type_pipeline_dcache;
            b_din <= din_pipeline_dcache;
            b_strb <= pipeline_dcache_wstrb;
            b_mop <= pipeline_dcache_opflag;
            b_op <= pipeline_dcache_op;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (b_mop) begin
            if (b_op == 2'd0) begin
              vld[b_tag[WW-1:0]][b_idx] <= 1'b0;
              dty[b_tag[WW-1:0]][b_idx] <= 1'b0;
              state <= RESP;
              dcache_pipeline_done <= 1'b1;
            end else if (mt_go) begin
              // Line is copied out now, so it can be dropped at once.
              vld[mt_way][b_idx] <= 1'b0;
              dty[mt_way][b_idx] <= 1'b0;
              if (vld[mt_way][b_idx] && dty[mt_way][b_idx]) begin
                dcache_mem_req <= 1'b1;
                dcache_mem_wr <= 1'b1;
                addr_dcache_mem <=
                  {tags[mt_way][b_idx], b_idx, {LSB{1'b0}}};
                dout_dcache_mem <= data[mt_way][b_idx];
                state <= WB_REQ;
              end else begin
                state <= RESP;
                dcache_pipeline_done <= 1'b1;
              end
            end else begin
              state <= RESP;
              dcache_pipeline_done <= 1'b1;
            end
          end else if (hit) begin
            if (b_wr) begin
              data[hit_way][b_idx][bsel +: 32] <= hit_mword;
              dty[hit_way][b_idx] <= 1'b1;
            end else begin
              dout_dcache_pipeline <= hit_word;
            end
            state <= RESP;
            dcache_pipeline_done <= 1'b1;
          end else begin
            victim <= vic;
            dcache_mem_req <= 1'b1;
            if (vld[vic][b_idx] && dty[vic][b_idx]) begin
              dcache_mem_wr <= 1'b1;
              addr_dcache_mem <=
                {tags[vic][b_idx], b_idx, {LSB{1'b0}}};
              dout_dcache_mem <= data[vic][b_idx];
              state <= WB_REQ;
            end else begin
              dcache_mem_wr <= 1'b0;
              addr_dcache_mem <= fill_addr;
              state <= RF_REQ;
            end
          end
        end
        WB_REQ: begin
          if (mem_dcache_addrOK) begin
            dcache_mem_req <= 1'b0;
            state <= WB_WAIT;
          end
        end
        WB_WAIT: begin
          if (mem_dcache_dataOK) begin
            if (b_mop) begin
              state <= RESP;
              dcache_pipeline_done <= 1'b1;
            end else begin
              dcache_mem_req <= 1'b1;
              dcache_mem_wr <= 1'b0;
              addr_dcache_mem <= fill_addr;
              state <= RF_REQ;
            end
          end
        end
        RF_REQ: begin
          if (mem_dcache_addrOK) begin
            dcache_mem_req <= 1'b0;
            state <= RF_WAIT;
          end
        end
        RF_WAIT: begin
          if (mem_dcache_dataOK) begin
            rf_line <= din_mem_dcache;
            state <= REFILL;
          end
        end
        REFILL: begin
          data[victim][b_idx] <= rf_merged;
          tags[victim][b_idx] <= b_tag;
          vld[victim][b_idx] <= 1'b1;
          dty[victim][b_idx] <= b_wr;
          rr[b_idx] <= rr[b_idx] + 1'b1;
          if (!b_wr) dout_dcache_pipeline <= rf_line[bsel +: 32];
          state <= RESP;
          dcache_pipeline_done <= 1'b1;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
